// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writes beside ID: raises the
// stall request and registers operand-forwarding selects for the EXE stage.
module hazard_scoreboard #(
  parameter int unsigned AW         = 4,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              freeze,
  input  logic                              flush,
  input  logic                              id_valid,
  input  logic                              id_use_rn,
  input  logic                              id_two_src,
  input  logic [AW-1:0]                     id_rn,
  input  logic [AW-1:0]                     id_src2,
  input  logic                              id_wb_en,
  input  logic                              id_mem_r_en,
  input  logic [AW-1:0]                     id_dest,
  output logic                              hazard_detected,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]   ex_sel_rn,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]   ex_sel_src2,
  output logic [(2**AW)-1:0]                pending_mask,
  output logic [CNT_W-1:0]                  stall_cnt
);

  localparam int unsigned SEL_W = $clog2(PIPE_DEPTH + 1);
  localparam int unsigned NREG  = 2**AW;

  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [PIPE_DEPTH-1:0] wb_q, wb_d;
  logic [PIPE_DEPTH-1:0] ld_q, ld_d;
  logic [AW-1:0]         dest_q [PIPE_DEPTH];
  logic [AW-1:0]         dest_d [PIPE_DEPTH];
  logic [SEL_W-1:0]      ex_sel_rn_q, ex_sel_rn_d;
  logic [SEL_W-1:0]      ex_sel_src2_q, ex_sel_src2_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic [PIPE_DEPTH-1:0] match_rn, match_src2;
  logic [SEL_W-1:0]      sel_rn, sel_src2;
  logic                  hazard;
  logic                  bubble;
  logic [NREG-1:0]       pmask;

  always_comb begin
    match_rn   = '0;
    match_src2 = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      match_rn[k]   = id_valid && id_use_rn  && vld_q[k] && wb_q[k] && (dest_q[k] == id_rn);
      match_src2[k] = id_valid && id_two_src && vld_q[k] && wb_q[k] && (dest_q[k] == id_src2);
    end
  end

  // Walk oldest to youngest so the lowest matching entry overwrites last.
  always_comb begin
    sel_rn   = '0;
    sel_src2 = '0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      if (match_rn[PIPE_DEPTH-1-i])   sel_rn   = SEL_W'(PIPE_DEPTH - i);
      if (match_src2[PIPE_DEPTH-1-i]) sel_src2 = SEL_W'(PIPE_DEPTH - i);
    end
  end

  always_comb begin
    if (FWD_EN) hazard = (match_rn[0] || match_src2[0]) && ld_q[0];
    else        hazard = (|match_rn) || (|match_src2);
    hazard = hazard && !flush;
    bubble = hazard || flush;
  end

  always_comb begin
    pmask = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      if (vld_q[k] && wb_q[k]) pmask[dest_q[k]] = 1'b1;
    end
  end

  always_comb begin
    vld_d         = vld_q;
    wb_d          = wb_q;
    ld_d          = ld_q;
    dest_d        = dest_q;
    ex_sel_rn_d   = ex_sel_rn_q;
    ex_sel_src2_d = ex_sel_src2_q;
    stall_cnt_d   = stall_cnt_q;
    if (!freeze) begin
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        wb_d[k]   = wb_q[k-1];
        ld_d[k]   = ld_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
      vld_d[0]      = id_valid && !bubble;
      wb_d[0]       = id_wb_en;
      ld_d[0]       = id_mem_r_en;
      dest_d[0]     = id_dest;
      ex_sel_rn_d   = bubble ? '0 : sel_rn;
      ex_sel_src2_d = bubble ? '0 : sel_src2;
      if (hazard && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q         <= '0;
      wb_q          <= '0;
      ld_q          <= '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) dest_q[k] <= '0;
      ex_sel_rn_q   <= '0;
      ex_sel_src2_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      vld_q         <= vld_d;
      wb_q          <= wb_d;
      ld_q          <= ld_d;
      dest_q        <= dest_d;
      ex_sel_rn_q   <= ex_sel_rn_d;
      ex_sel_src2_q <= ex_sel_src2_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign hazard_detected = hazard;
  assign ex_sel_rn       = ex_sel_rn_q;
  assign ex_sel_src2     = ex_sel_src2_q;
  assign pending_mask    = pmask;
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: forwarding, stall-only and narrow-counter instances share ID stimulus.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze, flush;
  logic       id_valid, id_use_rn, id_two_src, id_wb_en, id_mem_r_en;
  logic [3:0] id_rn, id_src2, id_dest;

  logic        f_hz, s_hz, c_hz;
  logic [1:0]  f_srn, f_ss2, s_srn, s_ss2;
  logic [2:0]  c_srn, c_ss2;
  logic [15:0] f_pm, s_pm, c_pm;
  logic [15:0] f_cnt, s_cnt;
  logic [1:0]  c_cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(4), .PIPE_DEPTH(2), .FWD_EN(1'b1), .CNT_W(16)) u_f (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_use_rn(id_use_rn), .id_two_src(id_two_src), .id_rn(id_rn), .id_src2(id_src2),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard_detected(f_hz), .ex_sel_rn(f_srn), .ex_sel_src2(f_ss2),
    .pending_mask(f_pm), .stall_cnt(f_cnt));

  hazard_scoreboard #(.AW(4), .PIPE_DEPTH(2), .FWD_EN(1'b0), .CNT_W(16)) u_s (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_use_rn(id_use_rn), .id_two_src(id_two_src), .id_rn(id_rn), .id_src2(id_src2),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard_detected(s_hz), .ex_sel_rn(s_srn), .ex_sel_src2(s_ss2),
    .pending_mask(s_pm), .stall_cnt(s_cnt));

  hazard_scoreboard #(.AW(4), .PIPE_DEPTH(5), .FWD_EN(1'b0), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_use_rn(id_use_rn), .id_two_src(id_two_src), .id_rn(id_rn), .id_src2(id_src2),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard_detected(c_hz), .ex_sel_rn(c_srn), .ex_sel_src2(c_ss2),
    .pending_mask(c_pm), .stall_cnt(c_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // valid, use_rn, two_src, rn, src2, wb_en, load, dest
  task automatic set_id(input logic v, input logic ur, input logic ts, input logic [3:0] rn,
                        input logic [3:0] s2, input logic wb, input logic ld, input logic [3:0] d);
    id_valid = v; id_use_rn = ur; id_two_src = ts; id_rn = rn; id_src2 = s2;
    id_wb_en = wb; id_mem_r_en = ld; id_dest = d;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    freeze = 1'b0; flush = 1'b0;
    nop();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    freeze = 1'b0; flush = 1'b0; rst = 1'b0;
    nop();
    #3;
    check("rst_f_hz",  32'(f_hz),  32'd0);
    check("rst_f_sel", 32'({f_srn, f_ss2}), 32'd0);
    check("rst_f_pm",  32'(f_pm),  32'd0);
    check("rst_f_cnt", 32'(f_cnt), 32'd0);
    check("rst_c_cnt", 32'(c_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // ADD R1 ; SUB R3,R1,R2 -> forwarded from EXE/MEM
    do_reset();
    set_id(1, 0, 0, 4'd0, 4'd0, 1, 0, 4'd1);
    check("add_nohz", 32'(f_hz), 32'd0);
    tick();
    set_id(1, 1, 1, 4'd1, 4'd2, 1, 0, 4'd3);
    check("sub_nohz", 32'(f_hz), 32'd0);
    check("sub_pm",   32'(f_pm), 32'h0002);
    tick();
    nop();
    check("sub_sel_rn", 32'(f_srn), 32'd1);
    check("sub_sel_s2", 32'(f_ss2), 32'd0);

    // LDR R4 ; ADD R5,R4,R4 -> one load-use stall then select 2
    do_reset();
    set_id(1, 0, 0, 4'd0, 4'd0, 1, 1, 4'd4);
    tick();
    set_id(1, 1, 1, 4'd4, 4'd4, 1, 0, 4'd5);
    check("lu_hz1", 32'(f_hz), 32'd1);
    tick();
    check("lu_hz2", 32'(f_hz), 32'd0);
    check("lu_bubble_sel", 32'(f_srn), 32'd0);
    tick();
    nop();
    check("lu_sel_rn", 32'(f_srn), 32'd2);
    check("lu_sel_s2", 32'(f_ss2), 32'd2);
    check("lu_cnt",    32'(f_cnt), 32'd1);

    // ADD R1 ; ADD R1 ; ORR R6,R1 -> youngest producer wins
    do_reset();
    set_id(1, 0, 0, 4'd0, 4'd0, 1, 0, 4'd1);
    tick();
    set_id(1, 1, 0, 4'd7, 4'd0, 1, 0, 4'd1);
    tick();
    set_id(1, 1, 0, 4'd1, 4'd0, 1, 0, 4'd6);
    check("two_nohz", 32'(f_hz), 32'd0);
    tick();
    nop();
    check("two_sel_rn", 32'(f_srn), 32'd1);

    // stall-only: ADD R1 ; SUB R3,R1 -> two stall cycles
    do_reset();
    set_id(1, 0, 0, 4'd0, 4'd0, 1, 0, 4'd1);
    tick();
    set_id(1, 1, 0, 4'd1, 4'd0, 1, 0, 4'd3);
    check("so_hz1", 32'(s_hz), 32'd1);
    tick();
    check("so_hz2", 32'(s_hz), 32'd1);
    tick();
    check("so_hz3", 32'(s_hz), 32'd0);
    tick();
    nop();
    check("so_sel_rn", 32'(s_srn), 32'd0);
    check("so_cnt",    32'(s_cnt), 32'd2);

    // flush during load-use: no stall, bubble enters, load still pending
    do_reset();
    set_id(1, 0, 0, 4'd0, 4'd0, 1, 1, 4'd4);
    tick();
    flush = 1'b1;
    set_id(1, 1, 0, 4'd4, 4'd0, 1, 0, 4'd5);
    check("fl_hz", 32'(f_hz), 32'd0);
    check("fl_pm", 32'(f_pm), 32'h0010);
    tick();
    flush = 1'b0;
    nop();
    check("fl_sel", 32'(f_srn), 32'd0);
    check("fl_cnt", 32'(f_cnt), 32'd0);
    check("fl_pm2", 32'(f_pm), 32'h0010);

    // freeze held 3 cycles during a load-use stall
    do_reset();
    set_id(1, 0, 0, 4'd0, 4'd0, 1, 1, 4'd4);
    tick();
    set_id(1, 1, 0, 4'd4, 4'd0, 1, 0, 4'd5);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fz_hz",  32'(f_hz),  32'd1);
      check("fz_cnt", 32'(f_cnt), 32'd0);
    end
    freeze = 1'b0;
    #1;
    tick();
    check("fz_after_cnt", 32'(f_cnt), 32'd1);
    check("fz_after_hz",  32'(f_hz),  32'd0);

    // depth 5, 2-bit counter: five stall cycles saturate at 3
    do_reset();
    set_id(1, 0, 0, 4'd0, 4'd0, 1, 0, 4'd1);
    tick();
    set_id(1, 1, 0, 4'd1, 4'd0, 1, 0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      check("sat_hz", 32'(c_hz), 32'd1);
      tick();
    end
    check("sat_done", 32'(c_hz),  32'd0);
    check("sat_cnt",  32'(c_cnt), 32'd3);

    // asynchronous reset in the middle of a stall
    do_reset();
    set_id(1, 0, 0, 4'd0, 4'd0, 1, 0, 4'd1);
    tick();
    set_id(1, 1, 0, 4'd1, 4'd0, 1, 0, 4'd3);
    tick();
    check("ar_pre_hz", 32'(c_hz), 32'd1);
    rst = 1'b0;
    #1;
    check("ar_hz",  32'(c_hz),  32'd0);
    check("ar_pm",  32'(c_pm),  32'd0);
    check("ar_cnt", 32'(c_cnt), 32'd0);
    check("ar_s_hz", 32'(s_hz), 32'd0);
    check("ar_s_cnt", 32'(s_cnt), 32'd0);
    rst = 1'b1;
    nop();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline's two-stage compare-only hazard detector; it sits beside the ID stage and replaces it.
- Tracks every in-flight register write in a shift-register scoreboard `PIPE_DEPTH` entries deep.
- Selectable mode: stall-only (`FWD_EN=0`) or forwarding with load-use stall (`FWD_EN=1`).
- Outputs a stall request to IF/ID and registered operand-forwarding selects that arrive with the instruction in EXE.
- Keeps a saturating stall counter for performance analysis.

## Interface
- `AW`, 4: register address width.
- `PIPE_DEPTH`, 2: number of post-ID stages whose writes are not yet visible in the register file (entry 0 = EXE, entry 1 = MEM, …). Range 1..7.
- `FWD_EN`, 1: 0 = stall on any match; 1 = forward, stall only on load-use.
- `CNT_W`, 16: stall counter width.
- `SEL_W` (derived, local): $clog2(PIPE_DEPTH+1).

Ports:
- `clk`, in, 1: clock. One clock, all state on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-low.
- `freeze`, in, 1: whole pipeline held; scoreboard and selects hold.
- `flush`, in, 1: ID instruction is killed this cycle.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_use_rn`, in, 1: instruction reads Rn.
- `id_two_src`, in, 1: instruction reads second source.
- `id_rn`, in, AW: Rn address.
- `id_src2`, in, AW: second source address (Rm, or Rd for store).
- `id_wb_en`, in, 1: instruction writes a register.
- `id_mem_r_en`, in, 1: instruction is a load.
- `id_dest`, in, AW: destination address.
- `hazard_detected`, out, 1: combinational stall request for PC, IF/ID, and bubble into ID/EXE.
- `ex_sel_rn`, out, SEL_W: registered Rn operand source for the instruction now in EXE.
- `ex_sel_src2`, out, SEL_W: registered second-operand source for the instruction now in EXE.
- `pending_mask`, out, 2**AW: bit r set when any valid entry has `wb_en` and `dest == r`.
- `stall_cnt`, out, CNT_W: cycles stalled.

## Operation
- Entry fields: valid, wb_en, dest, is_load.
- Match on entry k for source s:
  - entry k valid, wb_en set, dest == s;
  - the source is used (`id_use_rn` for Rn, `id_two_src` for src2);
  - `id_valid` is 1.
- `FWD_EN=0`: `hazard_detected` = any match on any entry.
- `FWD_EN=1`: `hazard_detected` = a match on entry 0 with is_load set. All other matches forward.
- Forward source: the youngest matching entry (lowest k) wins. Select code = k+1, or 0 when there is no match.
- Select code meaning, seen from EXE:
  - 0: register-file value.
  - 1: EXE/MEM alu_res.
  - 2: MEM/WB write-back value.
  - n: stage n output.
- `hazard_detected` is forced to 0 when `flush`=1.
- Advance when `freeze`=0:
  - entries shift k → k+1, and the oldest entry drops out;
  - entry 0 loads the ID instruction (valid = `id_valid`, with `id_wb_en`, `id_dest`, `id_mem_r_en`);
  - entry 0 loads a bubble (valid=0) if `hazard_detected` or `flush`.
- The `ex_sel_*` registers load the computed codes on advance, or 0 on a bubble.
- `freeze`=1: all registers hold. `hazard_detected` is still computed, and `stall_cnt` does not count.
- `stall_cnt` increments when `hazard_detected` and not `freeze`. It saturates at all-ones.
- Register-file writes from WB are visible to the ID read in the same cycle, so WB is not tracked.

## Timing
- Reset values: all entries invalid, `ex_sel_rn`=`ex_sel_src2`=0, `stall_cnt`=0, `pending_mask`=0, `hazard_detected`=0 (no valid entries).
- `hazard_detected` and `pending_mask`: combinational from entries and ID inputs, zero latency.
- `ex_sel_*`: valid one cycle after the instruction leaves ID, aligned with the instruction in EXE.
- Load-use, `FWD_EN=1`: exactly one stall cycle. On the retry the load is in entry 1 and the select is 2.
- `FWD_EN=0`, dependency on entry 0: `PIPE_DEPTH` stall cycles. Dependency on entry k: `PIPE_DEPTH`−k stall cycles.
- `flush` and `hazard_detected` together: flush wins; a bubble is inserted with no stall.
- `freeze` and `flush` together: hold; the flush is ignored (the owning stage re-presents it).
- Reset asserted mid-stall: entries clear immediately and `hazard_detected` drops asynchronously.
- Dest-equals-source in the same instruction (e.g. ADD R1,R1,R2): no self-match, because the instruction is not in the scoreboard yet.

## Test plan
- Default params, FWD_EN=1: ADD R1 then SUB R3,R1,R2 → no stall; SUB has `ex_sel_rn`=1, `ex_sel_src2`=0.
- FWD_EN=1: LDR R4 then ADD R5,R4,R4 (two_src) → `hazard_detected` 1 for exactly one cycle; then `ex_sel_rn`=`ex_sel_src2`=2; `stall_cnt`=1.
- FWD_EN=1, two producers: ADD R1; ADD R1; ORR R6,R1 → select 1 (youngest), not 2.
- FWD_EN=0: ADD R1 then SUB R3,R1 → two stall cycles; `ex_sel_*`=0; `stall_cnt`=2.
- Boundary: `flush` during a load-use stall → `hazard_detected`=0, bubble enters, `pending_mask` still shows the load dest. With `freeze` held 3 cycles, `stall_cnt` stays constant.
- `stall_cnt` with CNT_W=2 driven with 5 stall cycles → reads 3. Reset pulse mid-stall → all outputs return to 0 asynchronously.
